// File: rtl/baseerat_demux_if.sv
// Stream bundle between a single-input source and the two-output demux.
// Pure wiring, no latency.
// Carries both valid/ready handshakes, so backpressure passes straight through.
interface baseerat_demux_if #(
   parameter int DATA_WIDTH = 16
);
   logic [DATA_WIDTH-1:0] din;
   logic                  din_valid;
   logic                  din_last;
   logic                  din_ready;
   logic                  sel;
   logic [DATA_WIDTH-1:0] dout0;
   logic                  dout0_valid;
   logic                  dout0_last;
   logic                  dout0_ready;
   logic [DATA_WIDTH-1:0] dout1;
   logic                  dout1_valid;
   logic                  dout1_last;
   logic                  dout1_ready;
   logic                  busy;

   // Source side: drives the input stream and the sink readies.
   modport master (
      output din, din_valid, din_last, sel, dout0_ready, dout1_ready,
      input  din_ready, dout0, dout0_valid, dout0_last,
             dout1, dout1_valid, dout1_last, busy
   );

   // Demux side.
   modport slave (
      input  din, din_valid, din_last, sel, dout0_ready, dout1_ready,
      output din_ready, dout0, dout0_valid, dout0_last,
             dout1, dout1_valid, dout1_last, busy
   );
endinterface

// File: rtl/baseerat_demux.sv
// Packet-granular 1:2 stream demux; sel picks the port on each packet's first beat (1 -> port 0).
// Latency 0 with REG_OUT=0, 1 cycle with REG_OUT=1 (2-entry skid buffer per port).
// din_ready follows the routed port only: its ready (REG_OUT=0) or its buffer not full (REG_OUT=1).
module baseerat_demux #(
   parameter int DATA_WIDTH = 16,
   parameter bit REG_OUT    = 1'b1
) (
   input logic             clk,
   input logic             resetn,
   baseerat_demux_if.slave io
);
   typedef enum logic {IDLE = 1'b0, PKT = 1'b1} state_t;

   state_t state_q, state_d;
   logic   route_q, route_d;
   logic   route;     // 1 -> port 0, 0 -> port 1
   logic   accept;

   // Per-port view of the output streams, {last, data}.
   logic [1:0][DATA_WIDTH:0] out_dat;
   logic [1:0]               out_vld;
   logic [1:0]               out_rdy;

   assign out_rdy = {io.dout1_ready, io.dout0_ready};
   assign route   = (state_q == IDLE) ? io.sel : route_q;
   assign accept  = io.din_valid & io.din_ready;
   assign io.busy = (state_q == PKT);

   // Packet state and latched route.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= IDLE;
         route_q <= 1'b0;
      end else begin
         state_q <= state_d;
         route_q <= route_d;
      end
   end

   // Enter PKT on an accepted non-last first beat, leave on the accepted last beat.
   always_comb begin
      state_d = state_q;
      route_d = route_q;
      case (state_q)
         IDLE: if (accept && !io.din_last) begin
            state_d = PKT;
            route_d = io.sel;
         end
         PKT: if (accept && io.din_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   if (REG_OUT) begin : g_reg
      logic [1:0] full;

      for (genvar p = 0; p < 2; p++) begin : g_port
         logic [DATA_WIDTH:0] mem0, mem1;
         logic                wr_ptr, rd_ptr;
         logic [1:0]          cnt;
         logic                push, pop;

         assign push = accept & (route == (p == 0));
         assign pop  = (cnt != 2'd0) & out_rdy[p];

         // Two-entry ring buffer; cleared on reset so idle outputs read zero.
         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               mem0   <= '0;
               mem1   <= '0;
               wr_ptr <= 1'b0;
               rd_ptr <= 1'b0;
               cnt    <= 2'd0;
            end else begin
               if (push) begin
                  if (wr_ptr) mem1 <= {io.din_last, io.din};
                  else        mem0 <= {io.din_last, io.din};
                  wr_ptr <= ~wr_ptr;
               end
               if (pop) rd_ptr <= ~rd_ptr;
               cnt <= cnt + {1'b0, push} - {1'b0, pop};
            end
         end

         assign full[p]    = (cnt == 2'd2);
         assign out_vld[p] = (cnt != 2'd0);
         assign out_dat[p] = rd_ptr ? mem1 : mem0;
      end

      // Ready depends only on buffer occupancy, never on the sink readies.
      assign io.din_ready = resetn & (route ? ~full[0] : ~full[1]);
   end else begin : g_comb
      assign out_vld[0]   = resetn & io.din_valid & route;
      assign out_vld[1]   = resetn & io.din_valid & ~route;
      assign out_dat[0]   = resetn ? {io.din_last, io.din} : '0;
      assign out_dat[1]   = resetn ? {io.din_last, io.din} : '0;
      assign io.din_ready = resetn & (route ? out_rdy[0] : out_rdy[1]);
   end

   assign io.dout0       = out_dat[0][DATA_WIDTH-1:0];
   assign io.dout0_last  = out_dat[0][DATA_WIDTH];
   assign io.dout0_valid = out_vld[0];
   assign io.dout1       = out_dat[1][DATA_WIDTH-1:0];
   assign io.dout1_last  = out_dat[1][DATA_WIDTH];
   assign io.dout1_valid = out_vld[1];
endmodule

// File: doc/baseerat_demux.md
Name: baseerat_demux

Overview:
- Valid/ready stream demultiplexer, 1 input stream to 2 output streams; the opposite direction of baseerat_mux.
- Routing is packet-granular: sel is sampled on the first beat of each packet and held until the beat with din_last is accepted.
- Optional per-output 2-entry skid buffer (REG_OUT=1) breaks the ready path and sustains full throughput.
- Sits in front of split datapaths that must receive whole, unbroken packets.

Parameters:
- DATA_WIDTH, 16, width of the data bus (any value ≥1).
- REG_OUT, 1, 1 = registered outputs with skid buffers; 0 = combinational pass-through.

Ports:
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  asynchronous active-low reset.
- din  in  DATA_WIDTH  input data.
- din_valid  in  1  input beat valid.
- din_last  in  1  final beat of the packet.
- din_ready  out  1  input beat accepted when din_valid & din_ready.
- sel  in  1  route select: 1 → port 0, 0 → port 1; sampled on the first beat only.
- dout0 / dout0_valid / dout0_last  out  DATA_WIDTH / 1 / 1  port 0 stream.
- dout0_ready  in  1  port 0 sink ready.
- dout1 / dout1_valid / dout1_last  out  DATA_WIDTH / 1 / 1  port 1 stream.
- dout1_ready  in  1  port 1 sink ready.
- busy  out  1  high while mid-packet (FSM in PKT).

Behaviour:
- Reset (resetn low, asynchronous):
  - FSM goes to IDLE and skid buffers empty.
  - dout0_valid = dout1_valid = 0, dout0 = dout1 = 0, last outputs = 0, busy = 0.
  - din_ready = 0 while resetn is low.
- Reset mid-packet abandons the packet and discards buffered beats. The first beat after reset is treated as a packet start.
- FSM:
  - IDLE: route = sel (live). An accepted beat with din_last=0 latches route_q = sel and moves to PKT. An accepted beat with din_last=1 is a single-beat packet; the FSM stays in IDLE.
  - PKT: route = route_q. Changes on sel are ignored. An accepted beat with din_last=1 returns to IDLE on the next edge.
  - No beat accepted: state holds.
- Handshake, both sides:
  - Once valid is asserted it stays high, with data and last stable, until ready.
  - Outputs must obey this rule. The input is assumed to obey it.
- REG_OUT=0:
  - doutX = din and doutX_last = din_last for both ports.
  - doutX_valid = din_valid & (route==X). The non-routed port's valid is 0.
  - din_ready = routed port's doutX_ready. Zero latency.
- REG_OUT=1:
  - Each port has a 2-entry skid buffer. Latency is 1 cycle from acceptance to doutX_valid.
  - din_ready = routed buffer not full. This is a registered/occupancy function with no combinational path from doutX_ready.
  - Continuous ready gives 1 beat/cycle.
  - Beat order is preserved per port.
  - The previous packet may still drain from one port while the next packet enters the other port.
- Backpressure on the non-routed port never stalls the input.
- din_valid=0 with din_ready=1 is legal; no state change.

Test Plan:
- Reset: resetn low with din_valid=1 → din_ready=0, both valids 0, busy=0. Deassert → din_ready=1 (REG_OUT=1) on the first edge.
- Packet routing: 4-beat packet 0x0001..0x0004, sel=1 on beat 0, sel toggled on beats 1–3 → all 4 beats on dout0 in order, last only on 0x0004, busy=1 from beat 0 acceptance until beat 3 acceptance, dout1_valid never 1.
- Back-to-back alternating single-beat packets 0xA0 (sel=1), 0xB0 (sel=0) with both readies=1, REG_OUT=1 → 1 beat/cycle, dout0=0xA0 and dout1=0xB0 one cycle after acceptance, busy stays 0.
- Backpressure: dout0_ready=0, 3-beat packet to port 0, REG_OUT=1 → 2 beats accepted then din_ready=0. Raise ready → beats drain in order, third accepted, no loss or duplication. Hold dout1_ready=0 meanwhile → no effect.
- REG_OUT=0: sel=0, din=0x1234, din_valid=1, dout1_ready=0 → dout1=0x1234 with dout1_valid=1 the same cycle, din_ready=0, dout0_valid=0.
- Reset mid-packet: assert resetn low after beat 2 of 5 → outputs cleared immediately. Next packet with sel=0 goes to port 1 despite the abandoned packet targeting port 0.
